sram_like_arb_bridge: RTL

SRAM_LIKE_ARB_BRIDGE -- requirements
Module: sram_like_arb_bridge

---
 rtl/sram_like_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/sram_like_arb_bridge.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-like arbitration bridge.
package sram_like_pkg;

  // Bridge transfer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // sram-like transfer size encodings
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Arbitration modes
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Byte-enable pattern to transfer size; reads (0000) and odd patterns are word sized
  function automatic logic [1:0] decode_size(input logic [3:0] we);
    logic [1:0] size;
    case (we)
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      default:                            size = SIZE_WORD;
    endcase
    return size;
  endfunction

  // Address not naturally aligned for the given size
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_WORD) && (addr_lo != 2'b00)) ||
           ((size == SIZE_HALF) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter: fixed priority (lowest index) or round-robin, one-hot grant.
module rr_arbiter
  import sram_like_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = ARB_RR,
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] grant_idx;

  // Search the request vector, starting after the last winner in round-robin mode
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == ARB_FIXED) begin
        cand = IDX_W'(k);
      end else begin
        cand = IDX_W'((int'(ptr_reg) + 1 + k) % NUM_CH);
      end
      if (!found && req[cand]) begin
        found           = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = cand;
      end
    end
  end

  // Remember the last granted index; it only moves when a grant is taken
  always_ff @(posedge clk) begin
    if (!areset) begin
      ptr_reg <= IDX_W'(NUM_CH - 1);
    end else if (advance && (|req)) begin
      ptr_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/sram_like_arb_bridge.sv
// Multi-channel SRAM-style CPU ports arbitrated onto one sram-like master.
module sram_like_arb_bridge
  import sram_like_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic [NUM_CH-1:0]      s_en,
  input  logic [4*NUM_CH-1:0]    s_we,
  input  logic [32*NUM_CH-1:0]   s_addr,
  input  logic [32*NUM_CH-1:0]   s_wdata,
  output logic [32*NUM_CH-1:0]   s_rdata,
  output logic [NUM_CH-1:0]      stall,
  output logic [NUM_CH-1:0]      addr_exc,
  input  logic                   pipelineStall,
  output logic                   sl_req,
  output logic                   sl_wr,
  output logic [1:0]             sl_size,
  output logic [31:0]            sl_addr,
  output logic [31:0]            sl_wdata,
  input  logic [31:0]            sl_rdata,
  input  logic                   sl_addr_ok,
  input  logic                   sl_data_ok
);

  state_e            state_reg, state_next;
  logic [NUM_CH-1:0] requesting;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] gnt_oh_reg;
  logic              take_grant;
  logic              capture;

  logic [3:0]        we_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic [1:0]        size_reg;

  logic [3:0]        sel_we;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;

  // Per-channel decode, served flag and read-data holding register
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [1:0]  size_dec;
    logic        served_reg;
    logic [31:0] rdata_reg;

    assign size_dec       = decode_size(s_we[gi*4 +: 4]);
    assign addr_exc[gi]   = s_en[gi] & misaligned(size_dec, s_addr[gi*32 +: 2]);
    assign requesting[gi] = s_en[gi] & ~addr_exc[gi] & ~served_reg;
    assign s_rdata[gi*32 +: 32] = rdata_reg;

    // Capture returned data for the granted channel; served holds until the pipeline moves
    always_ff @(posedge clk) begin
      if (!areset) begin
        served_reg <= 1'b0;
        rdata_reg  <= '0;
      end else if (capture && gnt_oh_reg[gi]) begin
        served_reg <= 1'b1;
        rdata_reg  <= sl_rdata;
      end else if (served_reg && !pipelineStall) begin
        served_reg <= 1'b0;
      end
    end
  end

  // Hold every CPU channel while reset is asserted
  assign stall = areset ? requesting : {NUM_CH{1'b1}};

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk     (clk),
    .areset  (areset),
    .req     (requesting),
    .advance (take_grant),
    .grant   (grant)
  );

  // Mux the winning channel's request fields
  always_comb begin
    sel_we    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_we    = s_we[i*4 +: 4];
        sel_addr  = s_addr[i*32 +: 32];
        sel_wdata = s_wdata[i*32 +: 32];
      end
    end
  end

  // Next-state and handshake decode; responses in IDLE are ignored
  always_comb begin
    state_next = state_reg;
    take_grant = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|requesting) begin
          take_grant = 1'b1;
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (sl_data_ok) begin
          capture    = 1'b1;
          state_next = ST_IDLE;
        end else if (sl_addr_ok) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (sl_data_ok) begin
          capture    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (!areset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latch the granted request so later channel input changes cannot disturb it
  always_ff @(posedge clk) begin
    if (!areset) begin
      we_reg     <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      size_reg   <= SIZE_BYTE;
      gnt_oh_reg <= '0;
    end else if (take_grant) begin
      we_reg     <= sel_we;
      addr_reg   <= sel_addr;
      wdata_reg  <= sel_wdata;
      size_reg   <= decode_size(sel_we);
      gnt_oh_reg <= grant;
    end
  end

  assign sl_req   = (state_reg == ST_ADDR);
  assign sl_wr    = |we_reg;
  assign sl_size  = size_reg;
  assign sl_addr  = addr_reg;
  assign sl_wdata = wdata_reg;

endmodule
